// File: rtl/mem_access.sv
// Yarc memory stage: loads/stores over a req/gnt/rvalid data port.
// Stalls the pipeline while an access is outstanding and drives MEM/WB.
package mem_pkg;
    typedef enum logic [3:0] {
        MEM_NOP,
        MEM_LB,
        MEM_LBU,
        MEM_LH,
        MEM_LHU,
        MEM_LW,
        MEM_SB,
        MEM_SH,
        MEM_SW
    } mem_oper_t;
endpackage

module mem_access
    import mem_pkg::*;
(
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] alu_oper2_i,
    input  mem_oper_t   mem_oper_i,
    input  logic        wb_use_mem_i,
    input  logic        write_rd_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [31:0] wb_data_o,
    output logic        wb_use_mem_o,
    output logic        write_rd_o,
    output logic [4:0]  rd_addr_o,
    output logic        misaligned_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RVALID
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  off_q;
    mem_oper_t   op_q;

    logic        is_load;
    logic        is_store;
    logic        is_half;
    logic        is_word;
    logic        misaligned;
    logic        mem_valid;
    logic        req;
    logic        stall;
    logic        latch_ld;
    logic [1:0]  off;
    logic [31:0] rsh;
    logic [15:0] half;
    logic [31:0] ld_data;
    logic [31:0] wb_data_d;

    assign off = alu_result_i[1:0];

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        unique case (mem_oper_i)
            MEM_LB, MEM_LBU: is_load = 1'b1;
            MEM_LH, MEM_LHU: begin
                is_load = 1'b1;
                is_half = 1'b1;
            end
            MEM_LW: begin
                is_load = 1'b1;
                is_word = 1'b1;
            end
            MEM_SB: is_store = 1'b1;
            MEM_SH: begin
                is_store = 1'b1;
                is_half  = 1'b1;
            end
            MEM_SW: begin
                is_store = 1'b1;
                is_word  = 1'b1;
            end
            default: ;
        endcase
    end

    assign misaligned = (is_half & off[0]) | (is_word & (|off));
    assign mem_valid  = (is_load | is_store) & ~misaligned;

    always_comb begin
        dmem_be_o    = 4'b0001 << off;
        dmem_wdata_o = {4{alu_oper2_i[7:0]}};
        if (is_word) begin
            dmem_be_o    = 4'b1111;
            dmem_wdata_o = alu_oper2_i;
        end else if (is_half) begin
            dmem_be_o    = off[1] ? 4'b1100 : 4'b0011;
            dmem_wdata_o = {2{alu_oper2_i[15:0]}};
        end
    end

    assign dmem_addr_o = {alu_result_i[31:2], 2'b00};
    assign dmem_we_o   = is_store;

    // Request fields stay stable in WAIT_GNT because EX/MEM is frozen.
    always_comb begin
        req     = 1'b0;
        stall   = 1'b0;
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    req = 1'b1;
                    if (!dmem_gnt_i) begin
                        stall   = 1'b1;
                        state_d = WAIT_GNT;
                    end else if (is_load) begin
                        stall   = 1'b1;
                        state_d = WAIT_RVALID;
                    end
                end
            end
            WAIT_GNT: begin
                req = 1'b1;
                if (!dmem_gnt_i) begin
                    stall = 1'b1;
                end else if (is_load) begin
                    stall   = 1'b1;
                    state_d = WAIT_RVALID;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_RVALID: begin
                if (dmem_rvalid_i) begin
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dmem_req_o = req & rstn_i;
    assign stall_o    = stall & rstn_i;
    assign latch_ld   = (state_d == WAIT_RVALID) &&
                        (state_q != WAIT_RVALID);

    assign rsh  = dmem_rdata_i >> {off_q, 3'b000};
    assign half = off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];

    always_comb begin
        ld_data = dmem_rdata_i;
        unique case (op_q)
            MEM_LB:  ld_data = {{24{rsh[7]}}, rsh[7:0]};
            MEM_LBU: ld_data = {24'h0, rsh[7:0]};
            MEM_LH:  ld_data = {{16{half[15]}}, half};
            MEM_LHU: ld_data = {16'h0, half};
            default: ld_data = dmem_rdata_i;
        endcase
    end

    // Loads only ever retire out of WAIT_RVALID; a misaligned op keeps
    // its faulting address as the writeback value.
    assign wb_data_d = (wb_use_mem_i && state_q == WAIT_RVALID) ?
                       ld_data : alu_result_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            off_q        <= 2'b00;
            op_q         <= MEM_NOP;
            wb_data_o    <= 32'h0;
            wb_use_mem_o <= 1'b0;
            write_rd_o   <= 1'b0;
            rd_addr_o    <= 5'h0;
            misaligned_o <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch_ld) begin
                off_q <= off;
                op_q  <= mem_oper_i;
            end
            if (flush_i || stall) begin
                wb_data_o    <= 32'h0;
                wb_use_mem_o <= 1'b0;
                write_rd_o   <= 1'b0;
                rd_addr_o    <= 5'h0;
                misaligned_o <= 1'b0;
            end else begin
                wb_data_o    <= wb_data_d;
                wb_use_mem_o <= wb_use_mem_i;
                write_rd_o   <= write_rd_i & ~misaligned;
                rd_addr_o    <= rd_addr_i;
                misaligned_o <= misaligned;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed vectors, expected MEM/WB entries queued
// by the driver and checked by an independent monitor.
`timescale 1ns/1ps
module tb_mem_access;
    import mem_pkg::*;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic [31:0] alu_result_i = '0;
    logic [31:0] alu_oper2_i = '0;
    mem_oper_t   mem_oper_i = MEM_NOP;
    logic        wb_use_mem_i = 1'b0;
    logic        write_rd_i = 1'b0;
    logic [4:0]  rd_addr_i = '0;
    logic        flush_i = 1'b0;
    logic        stall_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i = 1'b0;
    logic        dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;
    logic [31:0] wb_data_o;
    logic        wb_use_mem_o;
    logic        write_rd_o;
    logic [4:0]  rd_addr_o;
    logic        misaligned_o;

    mem_access dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .alu_result_i (alu_result_i),
        .alu_oper2_i  (alu_oper2_i),
        .mem_oper_i   (mem_oper_i),
        .wb_use_mem_i (wb_use_mem_i),
        .write_rd_i   (write_rd_i),
        .rd_addr_i    (rd_addr_i),
        .flush_i      (flush_i),
        .stall_o      (stall_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_gnt_i   (dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i (dmem_rdata_i),
        .wb_data_o    (wb_data_o),
        .wb_use_mem_o (wb_use_mem_o),
        .write_rd_o   (write_rd_o),
        .rd_addr_o    (rd_addr_o),
        .misaligned_o (misaligned_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] data;
        logic        chk_data;
        logic        use_mem;
        logic        wr;
        logic [4:0]  rd;
        logic        mis;
    } wb_t;

    wb_t exp_q[$];
    int  n_pass = 0;
    int  n_total = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    endtask

    function automatic wb_t wb(logic [31:0] d, logic um, logic wr,
                               logic [4:0] rd, logic mis);
        wb_t e;
        e.data = d; e.chk_data = 1'b1; e.use_mem = um;
        e.wr = wr; e.rd = rd; e.mis = mis;
        return e;
    endfunction

    function automatic wb_t wb_nd(logic um, logic wr, logic [4:0] rd,
                                  logic mis);
        wb_t e;
        e = wb(32'h0, um, wr, rd, mis);
        e.chk_data = 1'b0;
        return e;
    endfunction

    function automatic wb_t bub();
        return wb(32'h0, 1'b0, 1'b0, 5'h0, 1'b0);
    endfunction

    task automatic op(mem_oper_t o, logic [31:0] a, logic [31:0] s,
                      logic um, logic wr, logic [4:0] rd);
        mem_oper_i   = o;
        alu_result_i = a;
        alu_oper2_i  = s;
        wb_use_mem_i = um;
        write_rd_i   = wr;
        rd_addr_i    = rd;
    endtask

    task automatic reqf(string nm, logic we, logic [3:0] be,
                        logic [31:0] a);
        #1;
        chk({nm, " we"}, 32'(dmem_we_o), 32'(we));
        chk({nm, " be"}, 32'(dmem_be_o), 32'(be));
        chk({nm, " addr"}, dmem_addr_o, a);
    endtask

    // One clock: check combinational handshake, queue the MEM/WB entry.
    task automatic step(string nm, logic es, logic er, wb_t e);
        @(negedge clk_i);
        chk({nm, " stall"}, 32'(stall_o), 32'(es));
        chk({nm, " req"}, 32'(dmem_req_o), 32'(er));
        exp_q.push_back(e);
        @(posedge clk_i);
        #2;
    endtask

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() > 0) begin
                wb_t e;
                e = exp_q.pop_front();
                if (e.chk_data) chk("wb_data", wb_data_o, e.data);
                chk("wb_use_mem", 32'(wb_use_mem_o), 32'(e.use_mem));
                chk("write_rd", 32'(write_rd_o), 32'(e.wr));
                chk("rd_addr", 32'(rd_addr_o), 32'(e.rd));
                chk("misaligned", 32'(misaligned_o), 32'(e.mis));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    mem_oper_t   lt_op[4];
    logic [31:0] lt_rd[4];
    logic [31:0] lt_ex[4];
    logic [3:0]  lt_be[4];

    initial begin
        lt_op = '{MEM_LB, MEM_LBU, MEM_LH, MEM_LHU};
        lt_rd = '{32'h00F00000, 32'h00F00000, 32'h00F00000, 32'h80000000};
        lt_ex = '{32'hFFFFFFF0, 32'h000000F0, 32'h000000F0, 32'h00008000};
        lt_be = '{4'b0100, 4'b0100, 4'b1100, 4'b1100};

        repeat (2) @(posedge clk_i);
        #1;
        chk("rst wb_data", wb_data_o, 32'h0);
        chk("rst write_rd", 32'(write_rd_o), 32'h0);
        chk("rst rd_addr", 32'(rd_addr_o), 32'h0);
        chk("rst misaligned", 32'(misaligned_o), 32'h0);
        chk("rst use_mem", 32'(wb_use_mem_o), 32'h0);
        chk("rst req", 32'(dmem_req_o), 32'h0);
        chk("rst stall", 32'(stall_o), 32'h0);
        #1;
        rstn_i = 1'b1;

        op(MEM_NOP, 32'h1234, 32'h0, 1'b0, 1'b1, 5'd5);
        dmem_gnt_i = 1'b1;
        step("alu", 1'b0, 1'b0, wb(32'h1234, 1'b0, 1'b1, 5'd5, 1'b0));
        dmem_gnt_i = 1'b0;

        op(MEM_NOP, 32'h55, 32'h0, 1'b0, 1'b1, 5'd6);
        flush_i = 1'b1;
        step("alu_flush", 1'b0, 1'b0, bub());
        flush_i = 1'b0;

        op(MEM_SB, 32'h1003, 32'h000000A5, 1'b0, 1'b0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            dmem_gnt_i = (i == 2);
            reqf("sb", 1'b1, 4'b1000, 32'h1000);
            chk("sb wdata", dmem_wdata_o, 32'hA5A5A5A5);
            if (i < 2) step("sb_wait", 1'b1, 1'b1, bub());
            else step("sb_gnt", 1'b0, 1'b1,
                      wb(32'h1003, 1'b0, 1'b0, 5'd0, 1'b0));
        end
        dmem_gnt_i = 1'b0;

        for (int i = 0; i < 4; i++) begin
            op(lt_op[i], 32'h2002, 32'h0, 1'b1, 1'b1, 5'd7);
            dmem_gnt_i = 1'b1;
            reqf("ld", 1'b0, lt_be[i], 32'h2000);
            step("ld_gnt", 1'b1, 1'b1, bub());
            dmem_gnt_i    = 1'b0;
            dmem_rvalid_i = 1'b1;
            dmem_rdata_i  = lt_rd[i];
            step("ld_rv", 1'b0, 1'b0, wb(lt_ex[i], 1'b1, 1'b1, 5'd7, 1'b0));
            dmem_rvalid_i = 1'b0;
        end

        op(MEM_LW, 32'h2000, 32'h0, 1'b1, 1'b1, 5'd8);
        step("lw_nogt", 1'b1, 1'b1, bub());
        dmem_gnt_i = 1'b1;
        step("lw_gnt", 1'b1, 1'b1, bub());
        dmem_gnt_i = 1'b0;
        step("lw_norv", 1'b1, 1'b0, bub());
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hDEADBEEF;
        step("lw_rv", 1'b0, 1'b0, wb(32'hDEADBEEF, 1'b1, 1'b1, 5'd8, 1'b0));
        dmem_rvalid_i = 1'b0;

        dmem_gnt_i = 1'b1;
        op(MEM_LW, 32'h3001, 32'h0, 1'b1, 1'b1, 5'd9);
        step("lw_mis", 1'b0, 1'b0, wb_nd(1'b1, 1'b0, 5'd9, 1'b1));
        op(MEM_SH, 32'h3003, 32'hBEEF, 1'b0, 1'b0, 5'd0);
        step("sh_mis", 1'b0, 1'b0, wb_nd(1'b0, 1'b0, 5'd0, 1'b1));

        op(MEM_LW, 32'h4000, 32'h0, 1'b1, 1'b1, 5'd3);
        step("flw_gnt", 1'b1, 1'b1, bub());
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h12345678;
        flush_i       = 1'b1;
        step("flw_rv", 1'b0, 1'b0, bub());
        flush_i       = 1'b0;
        dmem_rvalid_i = 1'b0;
        op(MEM_SW, 32'h4004, 32'h11223344, 1'b0, 1'b0, 5'd0);
        dmem_gnt_i = 1'b1;
        reqf("sw", 1'b1, 4'b1111, 32'h4004);
        chk("sw wdata", dmem_wdata_o, 32'h11223344);
        step("sw", 1'b0, 1'b1, wb(32'h4004, 1'b0, 1'b0, 5'd0, 1'b0));

        dmem_gnt_i = 1'b0;
        op(MEM_SW, 32'h5000, 32'h99, 1'b0, 1'b0, 5'd0);
        step("rsw_wait", 1'b1, 1'b1, bub());
        rstn_i = 1'b0;
        #1;
        chk("mid_rst req", 32'(dmem_req_o), 32'h0);
        chk("mid_rst stall", 32'(stall_o), 32'h0);
        chk("mid_rst wb_data", wb_data_o, 32'h0);
        chk("mid_rst write_rd", 32'(write_rd_o), 32'h0);
        @(posedge clk_i);
        #2;
        op(MEM_NOP, 32'h77, 32'h0, 1'b0, 1'b1, 5'd1);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hBADBAD00;
        rstn_i = 1'b1;
        step("post_rst", 1'b0, 1'b0, wb(32'h77, 1'b0, 1'b1, 5'd1, 1'b0));
        dmem_rvalid_i = 1'b0;

        op(MEM_LW, 32'h6000, 32'h0, 1'b1, 1'b1, 5'd2);
        dmem_gnt_i = 1'b1;
        step("lw2_gnt", 1'b1, 1'b1, bub());
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hCAFEF00D;
        step("lw2_rv", 1'b0, 1'b0, wb(32'hCAFEF00D, 1'b1, 1'b1, 5'd2, 1'b0));
        dmem_rvalid_i = 1'b0;

        op(MEM_NOP, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
        @(posedge clk_i);
        #2;
        chk("queue drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory stage of the Yarc 5-stage pipeline. It takes the EX/MEM pipeline register outputs of the execute stage and performs loads and stores on the data-memory port. It uses a req/gnt/rvalid handshake and stalls the pipeline while an access is outstanding. It then drives the MEM/WB pipeline registers, including the already-selected writeback data used for MEM/WB forwarding.

## Interface
- No parameters.
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous active-low reset.
- alu_result_i  in  32  ALU result from EX/MEM; used as the effective address for memory ops.
- alu_oper2_i  in  32  store data, taken from rs2 after forwarding.
- mem_oper_i  in  mem_oper_t  one of MEM_NOP, MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_SB, MEM_SH, MEM_SW.
- wb_use_mem_i, write_rd_i  in  1 each  writeback controls, passed through.
- rd_addr_i  in  5  destination register.
- flush_i  in  1  synchronous clear of the MEM/WB registers to a bubble.
- stall_o  out  1  combinational; the hazard unit must freeze IF, ID, EX and EX/MEM while this is high.
- dmem_req_o, dmem_we_o  out  1 each  request and write enable.
- dmem_be_o  out  4  byte enables.
- dmem_addr_o  out  32  word address, equal to {alu_result_i[31:2], 2'b00}.
- dmem_wdata_o  out  32  lane-replicated store data.
- dmem_gnt_i, dmem_rvalid_i  in  1 each  grant and read-data valid.
- dmem_rdata_i  in  32  read word.
- wb_data_o  out  32  MEM/WB: load data if wb_use_mem, otherwise alu_result.
- wb_use_mem_o, write_rd_o  out  1 each  MEM/WB controls.
- rd_addr_o  out  5  MEM/WB destination register.
- misaligned_o  out  1  MEM/WB flag: this instruction was a misaligned memory op.

## Operation
- **FSM states:** IDLE, WAIT_GNT, WAIT_RVALID. Reset state is IDLE.
- **Alignment rule:**
  - Halfword ops require addr[0]=0.
  - Word ops require addr[1:0]=0.
  - A misaligned op issues no request and does not stall. It retires into MEM/WB with misaligned_o=1 and write_rd_o=0.
- **Store lane encoding:**
  - SB: be = 4'b0001 << addr[1:0]; wdata = {4{rs2[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{rs2[15:0]}}.
  - SW: be = 4'b1111; wdata = rs2.
  - For loads, be follows the same rule and we=0.
- **IDLE:**
  - With a valid aligned memory op, dmem_req_o=1 combinationally.
  - If gnt=1 and the op is a store: it retires this cycle and stall_o=0.
  - If gnt=1 and the op is a load: go to WAIT_RVALID, latch addr[1:0] and the op, stall_o=1.
  - If gnt=0: go to WAIT_GNT, stall_o=1.
  - MEM_NOP: no request, no stall; retires a pass-through.
- **WAIT_GNT:**
  - Keep req and all request fields stable; EX/MEM is frozen by stall_o.
  - On gnt: a store retires (stall_o=0, next state IDLE); a load goes to WAIT_RVALID with stall_o=1.
- **WAIT_RVALID:**
  - stall_o=1 until dmem_rvalid_i.
  - On rvalid: stall_o=0, the load retires, next state IDLE.
  - rvalid is never expected in the same cycle as its gnt.
- **Load extraction:** uses the latched offset and op.
  - LB/LBU: byte at offset, sign- or zero-extended.
  - LH/LHU: half at offset[1], sign- or zero-extended.
  - LW: the whole word.
- **MEM/WB register, at each clock edge:**
  - If flush_i, or stall_o is high: load a bubble (all fields 0).
  - Otherwise: load the retiring instruction.
- **Events ignored in IDLE:** a stray dmem_rvalid_i and dmem_gnt_i with no request.

## Timing
- **Reset values:** all registered outputs are 0 and the state is IDLE. Reset mid-access abandons it; a late rvalid after reset is ignored.
- **Latency:**
  - Non-memory op and store with immediate gnt: 1 cycle, no stall.
  - Load with immediate gnt and rvalid the next cycle: stall_o high for 1 cycle; the result appears in MEM/WB 2 edges after entry.
  - Each cycle without gnt or rvalid adds one stall cycle.
- **flush_i and stall_o together:** the bubble is written; the FSM still advances normally.
- **Load completing under flush_i:** the data is discarded (write_rd_o=0).
- **Back-to-back memory ops:** the next op is presented the cycle after retirement and may request immediately from IDLE.

## Test plan
- ALU op (wb_use_mem=0, alu_result=0x1234, rd=5, write_rd=1) -> next edge wb_data_o=0x1234, rd_addr_o=5, stall_o never high, dmem_req_o=0.
- SB to addr 0x1003 with rs2=0x000000A5, gnt held low 2 cycles -> req stays high 3 cycles with be=4'b1000, wdata=0xA5A5A5A5; stall_o high 2 cycles; retires on the third.
- LB from 0x2002, rvalid one cycle after gnt with rdata=0x00F00000 -> wb_data_o=0xFFFFFFF0; LBU gives 0x000000F0; LH gives 0x000000F0; LHU from 0x2002 with rdata=0x80000000 gives 0x00008000.
- LW from 0x3001 -> no request, no stall, misaligned_o=1, write_rd_o=0; SH to 0x3003 behaves the same.
- Load in WAIT_RVALID with flush_i asserted the cycle rvalid arrives -> MEM/WB is a bubble, FSM returns to IDLE, and the next op issues normally.
- rstn_i pulsed low during WAIT_GNT -> all outputs 0 and dmem_req_o=0 immediately; a subsequent stray rvalid has no effect.
